// File: rtl/fir_mac_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : fir_mac_scheduler_if
// Brief    : Sample-in, result-out and coefficient-write bundle for the
//            time-multiplexed FIR engine.
// Revision : 1.0 - initial release
// ============================================================================
interface fir_mac_scheduler_if #(
  parameter int N_TAPS      = 4,
  parameter int DATA_WIDTH  = 18,
  parameter int COEFF_WIDTH = 18
);
  localparam int OUTPUT_WIDTH = DATA_WIDTH + COEFF_WIDTH + $clog2(N_TAPS);
  localparam int ADDR_WIDTH   = $clog2(N_TAPS);

  logic                           in_valid;
  logic                           in_ready;
  logic signed [DATA_WIDTH-1:0]   data_in;
  logic                           out_valid;
  logic                           out_ready;
  logic signed [OUTPUT_WIDTH-1:0] data_out;
  logic                           coeff_wr_en;
  logic        [ADDR_WIDTH-1:0]   coeff_wr_addr;
  logic signed [COEFF_WIDTH-1:0]  coeff_wr_data;

  modport master (
    output in_valid, data_in, out_ready, coeff_wr_en, coeff_wr_addr, coeff_wr_data,
    input  in_ready, out_valid, data_out
  );

  modport slave (
    input  in_valid, data_in, out_ready, coeff_wr_en, coeff_wr_addr, coeff_wr_data,
    output in_ready, out_valid, data_out
  );
endinterface
`default_nettype wire

// File: rtl/fir_mac_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : fir_mac_scheduler
// Brief    : FIR filter sharing a single multiplier-accumulator across all
//            taps; optional output clamp and sticky sat_flag via FIR_SAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fir_mac_scheduler #(
  parameter int N_TAPS      = 4,
  parameter int DATA_WIDTH  = 18,
  parameter int COEFF_WIDTH = 18,
  parameter int SAT_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  fir_mac_scheduler_if.slave    bus,
  output logic                  busy
`ifdef FIR_SAT_EN
  ,
  output logic                  sat_flag
`endif
);

  localparam int C_TAP_W       = $clog2(N_TAPS);
  localparam int C_PROD_W      = DATA_WIDTH + COEFF_WIDTH;
  localparam int OUTPUT_WIDTH  = C_PROD_W + C_TAP_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t                         r_state;
  state_t                         w_state_next;
  logic signed [DATA_WIDTH-1:0]   r_delay [N_TAPS];
  logic signed [COEFF_WIDTH-1:0]  r_coeff [N_TAPS];
  logic signed [OUTPUT_WIDTH-1:0] r_acc;
  logic        [C_TAP_W-1:0]      r_tap;
  logic signed [OUTPUT_WIDTH-1:0] r_data_out;

  logic                           w_in_ready;
  logic                           w_accept;
  logic                           w_last_tap;
  logic                           w_coeff_we;
  logic signed [C_PROD_W-1:0]     w_prod;
  logic signed [OUTPUT_WIDTH-1:0] w_sum;
  logic signed [OUTPUT_WIDTH-1:0] w_result;

  if (N_TAPS < 2 || SAT_WIDTH > OUTPUT_WIDTH) begin : g_param_check
    $error("fir_mac_scheduler: N_TAPS must be >= 2 and SAT_WIDTH <= OUTPUT_WIDTH");
  end

  assign w_in_ready = (r_state == S_IDLE) || ((r_state == S_OUT) && bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_last_tap = (r_tap == C_TAP_W'(N_TAPS - 1));
  // Coefficients only move while nothing is being computed or started.
  assign w_coeff_we = bus.coeff_wr_en && (r_state == S_IDLE) && !w_accept;

  assign w_prod = r_delay[r_tap] * r_coeff[r_tap];
  assign w_sum  = r_acc + {{C_TAP_W{w_prod[C_PROD_W-1]}}, w_prod};

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_state == S_OUT);
  assign bus.data_out  = r_data_out;
  assign busy          = (r_state == S_MAC) || (r_state == S_OUT);

`ifdef FIR_SAT_EN
  localparam logic signed [OUTPUT_WIDTH-1:0] C_SAT_MAX =
    {{(OUTPUT_WIDTH-SAT_WIDTH+1){1'b0}}, {(SAT_WIDTH-1){1'b1}}};
  localparam logic signed [OUTPUT_WIDTH-1:0] C_SAT_MIN =
    {{(OUTPUT_WIDTH-SAT_WIDTH+1){1'b1}}, {(SAT_WIDTH-1){1'b0}}};

  logic w_clamp;
  logic r_sat_flag;

  always_comb begin
    w_result = w_sum;
    w_clamp  = 1'b0;
    if (w_sum > C_SAT_MAX) begin
      w_result = C_SAT_MAX;
      w_clamp  = 1'b1;
    end else if (w_sum < C_SAT_MIN) begin
      w_result = C_SAT_MIN;
      w_clamp  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sat_flag <= 1'b0;
    end else if ((r_state == S_MAC) && w_last_tap && w_clamp) begin
      r_sat_flag <= 1'b1;
    end
  end

  assign sat_flag = r_sat_flag;
`else
  assign w_result = w_sum;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_next = S_MAC;
      end
      S_MAC: begin
        if (w_last_tap) w_state_next = S_OUT;
      end
      S_OUT: begin
        if (bus.out_ready) w_state_next = bus.in_valid ? S_MAC : S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc      <= '0;
      r_tap      <= '0;
      r_data_out <= '0;
    end else if (w_accept) begin
      r_acc <= '0;
      r_tap <= '0;
    end else if (r_state == S_MAC) begin
      r_acc <= w_sum;
      r_tap <= r_tap + C_TAP_W'(1);
      if (w_last_tap) r_data_out <= w_result;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < N_TAPS; k++) begin
        r_delay[k] <= '0;
      end
    end else if (w_accept) begin
      r_delay[0] <= bus.data_in;
      for (int k = 1; k < N_TAPS; k++) begin
        r_delay[k] <= r_delay[k-1];
      end
    end
  end

  // Out-of-range addresses match no tap and are thereby dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < N_TAPS; k++) begin
        r_coeff[k] <= COEFF_WIDTH'(10 * (k + 1));
      end
    end else if (w_coeff_we) begin
      for (int k = 0; k < N_TAPS; k++) begin
        if (int'(bus.coeff_wr_addr) == k) r_coeff[k] <= bus.coeff_wr_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fir_mac_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_mac_scheduler
// Brief    : Directed and randomized bench against a sum-of-products model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_mac_scheduler;
  localparam int N  = 4;
  localparam int DW = 18;
  localparam int CW = 18;
  localparam int OW = DW + CW + $clog2(N);
  localparam int SW = 20;
  localparam int AW = $clog2(N);

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic busy;
`ifdef FIR_SAT_EN
  logic sat_flag;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  longint m_coeff [N];
  longint m_hist  [N];
  longint m_last;
  logic   m_sat;

  fir_mac_scheduler_if #(.N_TAPS(N), .DATA_WIDTH(DW), .COEFF_WIDTH(CW)) bus ();

  fir_mac_scheduler #(
    .N_TAPS(N), .DATA_WIDTH(DW), .COEFF_WIDTH(CW), .SAT_WIDTH(SW)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .busy    (busy)
`ifdef FIR_SAT_EN
    ,
    .sat_flag(sat_flag)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < N; k++) begin
      m_coeff[k] = 10 * (k + 1);
      m_hist[k]  = 0;
    end
    m_last = 0;
    m_sat  = 1'b0;
  endfunction

  function automatic void model_push(input longint s);
    for (int k = N - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = s;
  endfunction

  // y[n] = sum coeff[k]*x[n-k], clamped when the saturation option is built in.
  function automatic longint model_out();
    longint s = 0;
    for (int k = 0; k < N; k++) s += m_coeff[k] * m_hist[k];
`ifdef FIR_SAT_EN
    if (s > (64'sd1 <<< (SW - 1)) - 1) begin s = (64'sd1 <<< (SW - 1)) - 1; m_sat = 1'b1; end
    if (s < -(64'sd1 <<< (SW - 1)))    begin s = -(64'sd1 <<< (SW - 1));    m_sat = 1'b1; end
`endif
    return s;
  endfunction

  task automatic do_reset();
    bus.in_valid    = 1'b0;
    bus.coeff_wr_en = 1'b0;
    bus.out_ready   = 1'b1;
    #3 reset_n = 1'b0;
    #1 check("reset_out_valid", bus.out_valid, 0);
    check("reset_busy", busy, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    model_reset();
  endtask

  task automatic write_coeff(input logic [AW-1:0] a, input longint v, input bit applies);
    bus.coeff_wr_en   = 1'b1;
    bus.coeff_wr_addr = a;
    bus.coeff_wr_data = CW'(v);
    @(posedge clk);
    #1 bus.coeff_wr_en = 1'b0;
    if (applies) m_coeff[a] = v;
  endtask

  task automatic accept(input longint s);
    bus.in_valid = 1'b1;
    bus.data_in  = DW'(s);
    #1 check("in_ready_before_accept", bus.in_ready, 1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    model_push(s);
    check("in_ready_mac0", bus.in_ready, 0);
    check("out_valid_mac0", bus.out_valid, 0);
    check("busy_mac0", busy, 1);
  endtask

  task automatic expect_result();
    longint e = model_out();
    for (int i = 1; i <= N; i++) begin
      @(posedge clk);
      #1;
      if (i < N) begin
        check("in_ready_mac", bus.in_ready, 0);
        check("out_valid_mac", bus.out_valid, 0);
      end else begin
        check("out_valid_latency", bus.out_valid, 1);
        check("data_out", bus.data_out, e);
        check("busy_out", busy, 1);
`ifdef FIR_SAT_EN
        check("sat_flag", sat_flag, m_sat);
`endif
      end
    end
    m_last = e;
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    #1 check("in_ready_out_ready", bus.in_ready, 1);
    @(posedge clk);
    #1 check("out_valid_drop", bus.out_valid, 0);
    check("data_out_retained", bus.data_out, m_last);
    check("in_ready_idle", bus.in_ready, 1);
  endtask

  task automatic one_sample(input longint s);
    accept(s);
    expect_result();
    drain();
  endtask

  initial begin
    logic signed [DW-1:0] rs;
    logic signed [CW-1:0] rc;
    int hold;

    bus.in_valid      = 1'b0;
    bus.data_in       = '0;
    bus.out_ready     = 1'b1;
    bus.coeff_wr_en   = 1'b0;
    bus.coeff_wr_addr = '0;
    bus.coeff_wr_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_data_out", bus.data_out, 0);

    // Latency then impulse response 10/20/30/40.
    one_sample(1);
    one_sample(0);
    one_sample(0);
    one_sample(0);

    // Step response 10/30/60/100/100.
    do_reset();
    repeat (5) one_sample(1);

    // Backpressure, then back-to-back accept during the output handshake.
    bus.out_ready = 1'b0;
    accept(7);
    expect_result();
    repeat (6) begin
      @(posedge clk);
      #1 check("bp_out_valid", bus.out_valid, 1);
      check("bp_data_out", bus.data_out, m_last);
      check("bp_in_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    accept(-3);
    expect_result();
    drain();

    // Coefficient write in IDLE, impulse gives 10/20/-5/40.
    do_reset();
    write_coeff(2'd2, -5, 1'b1);
    one_sample(1);
    repeat (3) one_sample(0);

    // Writes while accepting and during MAC/OUT are dropped.
    bus.coeff_wr_en   = 1'b1;
    bus.coeff_wr_addr = 2'd1;
    bus.coeff_wr_data = CW'(999);
    accept(5);
    expect_result();
    bus.coeff_wr_en = 1'b0;
    drain();
    one_sample(2);

    // Reset mid-MAC restores coefficients and clears the delay line.
    write_coeff(2'd0, 55, 1'b1);
    accept(9);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b0;
    #1 check("midmac_out_valid", bus.out_valid, 0);
    check("midmac_busy", busy, 0);
    check("midmac_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1 reset_n = 1'b1;
    model_reset();
    one_sample(1);
    check("post_reset_impulse", m_last, 10);

    // Randomized samples, coefficient updates and backpressure.
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        rc = CW'($urandom);
        write_coeff(AW'($urandom_range(0, N - 1)), longint'(rc), 1'b1);
      end
      rs   = DW'($urandom);
      hold = $urandom_range(0, 3);
      bus.out_ready = (hold == 0);
      accept(longint'(rs));
      expect_result();
      repeat (hold) begin
        @(posedge clk);
        #1 check("rnd_bp_data_out", bus.data_out, m_last);
      end
      drain();
    end

`ifdef FIR_SAT_EN
    do_reset();
    for (int k = 0; k < N; k++) write_coeff(AW'(k), 131071, 1'b1);
    repeat (N) one_sample(-131072);
    check("sat_clamp_value", bus.data_out, -524288);
    check("sat_flag_set", sat_flag, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
